// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master: FSM states, SPI modes, parameter limits.
// Latency: n/a (types, constants and a width helper only).
// Backpressure: n/a.
package spi_pkg;

   // Transfer sequencer states
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      XFER  = 2'd2,
      HOLD  = 2'd3
   } state_t;

   // SPI mode encoded as {CKP, CPH}
   typedef enum logic [1:0] {
      MODE0 = 2'b00,
      MODE1 = 2'b01,
      MODE2 = 2'b10,
      MODE3 = 2'b11
   } spi_mode_t;

   // Legal parameter ranges
   localparam int DATA_W_MIN = 2;
   localparam int DATA_W_MAX = 32;
   localparam int DIV_MIN    = 2;

   // Width of a select field for n targets (never narrower than one bit)
   function automatic int sel_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/spi_clkgen.sv
// SCK timebase: counts DIV system clocks per half-period, flags leading/trailing SCK edges.
// Latency: tick is combinational on the last count of each DIV-cycle block.
// Backpressure: none; counting restarts from zero whenever en is low.
module spi_clkgen
   import spi_pkg::*;
#(
   parameter int DIV = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic en,        // count while a transfer is active
   input  logic edge_en,   // ticks are real SCK edges (XFER phase)
   output logic tick,
   output logic lead,
   output logic trail
);

   localparam int CW = $clog2(DIV);
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt;
   logic          phase;   // 0: next SCK edge is leading, 1: trailing

   assign tick  = en && (cnt == LAST);
   assign lead  = tick && edge_en && !phase;
   assign trail = tick && edge_en &&  phase;

   // Half-period counter and edge-phase tracker
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt   <= '0;
         phase <= 1'b0;
      end else if (!en) begin
         cnt   <= '0;
         phase <= 1'b0;
      end else begin
         cnt <= tick ? '0 : cnt + 1'b1;
         if (tick && edge_en)
            phase <= ~phase;
      end
   end

endmodule

// File: rtl/spi_master_param.sv
// Parameterised SPI master, modes 0-3; optional LSB-first ordering under macro SPI_LSB_FIRST_EN.
// Latency: DONE pulses DIV*(2*DATA_W+2) clocks after the edge that accepts START.
// Backpressure: START is taken only in IDLE (including the DONE cycle); requests while BUSY are dropped.
module spi_master_param
   import spi_pkg::*;
#(
   parameter  int DATA_W = 16,
   parameter  int DIV    = 4,
   parameter  int NUM_CS = 2,
   localparam int SEL_W  = sel_width(NUM_CS)
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              CKP,
   input  logic              CPH,
   input  logic              START,
   input  logic [SEL_W-1:0]  CS_SEL,
   input  logic [DATA_W-1:0] TX_DATA,
`ifdef SPI_LSB_FIRST_EN
   input  logic              LSB_FIRST,
`endif
   input  logic              MISO,
   output logic              MOSI,
   output logic              SCK,
   output logic [NUM_CS-1:0] CS,
   output logic [DATA_W-1:0] RX_DATA,
   output logic              BUSY,
   output logic              DONE
);

   // An illegal DIV below the minimum is raised to the minimum
   localparam int DIV_E = (DIV < DIV_MIN) ? DIV_MIN : DIV;
   localparam int EW    = $clog2(2 * DATA_W);
   localparam logic [EW-1:0] LAST_EDGE = EW'(2 * DATA_W - 1);

   state_t            state, state_nxt;
   spi_mode_t         mode_q;
   logic              cph;
   logic              sck_q;
   logic [DATA_W-1:0] tx_sr, rx_sr;
   logic [DATA_W-1:0] tx_ord, rx_ord;
   logic [EW-1:0]     edge_cnt;
   logic [NUM_CS-1:0] cs_dec;
   logic              tick, lead, trail;
   logic              accept, last_edge, hold_done, shift_ev, sample_ev;

   spi_clkgen #(.DIV(DIV_E)) u_clkgen (
      .clk     (CLK),
      .rst     (RESET),
      .en      (state != IDLE),
      .edge_en (state == XFER),
      .tick    (tick),
      .lead    (lead),
      .trail   (trail)
   );

   assign cph       = (mode_q == MODE1) || (mode_q == MODE3);
   assign accept    = (state == IDLE) && START;
   assign last_edge = (state == XFER) && tick && (edge_cnt == LAST_EDGE);
   assign hold_done = (state == HOLD) && tick;
   // CPH=0 samples on leading edges and shifts on trailing; CPH=1 is the reverse
   assign shift_ev  = cph ? lead  : trail;
   assign sample_ev = cph ? trail : lead;
   // Idle SCK follows the live polarity input; during a transfer it uses the latched one
   assign SCK       = (state == IDLE) ? (CKP & ~RESET) : sck_q;

`ifdef SPI_LSB_FIRST_EN
   logic lsb_q;

   // Bit-reverse outgoing and assembled words when LSB-first is selected
   always_comb begin
      tx_ord = TX_DATA;
      rx_ord = rx_sr;
      if (LSB_FIRST)
         for (int i = 0; i < DATA_W; i++) tx_ord[i] = TX_DATA[DATA_W-1-i];
      if (lsb_q)
         for (int i = 0; i < DATA_W; i++) rx_ord[i] = rx_sr[DATA_W-1-i];
   end
`else
   assign tx_ord = TX_DATA;
   assign rx_ord = rx_sr;
`endif

   // Chip-select pattern for the requested target; out-of-range selects none
   always_comb begin
      cs_dec = '1;
      for (int i = 0; i < NUM_CS; i++)
         if (int'(CS_SEL) == i) cs_dec[i] = 1'b0;
   end

   // FSM state register
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) state <= IDLE;
      else       state <= state_nxt;
   end

   // FSM next-state: SETUP and HOLD last one tick, XFER lasts 2*DATA_W ticks
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (START)     state_nxt = SETUP;
         SETUP:   if (tick)      state_nxt = XFER;
         XFER:    if (last_edge) state_nxt = HOLD;
         HOLD:    if (tick)      state_nxt = IDLE;
         default:                state_nxt = IDLE;
      endcase
   end

   // Datapath: latch request, generate SCK, shift MOSI, assemble MISO, report completion
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         mode_q   <= MODE0;
         sck_q    <= 1'b0;
         tx_sr    <= '0;
         rx_sr    <= '0;
         edge_cnt <= '0;
         MOSI     <= 1'b0;
         CS       <= '1;
         RX_DATA  <= '0;
         BUSY     <= 1'b0;
         DONE     <= 1'b0;
`ifdef SPI_LSB_FIRST_EN
         lsb_q    <= 1'b0;
`endif
      end else begin
         DONE <= hold_done;
         if (accept) begin
            mode_q   <= spi_mode_t'({CKP, CPH});
            sck_q    <= CKP;
            CS       <= cs_dec;
            BUSY     <= 1'b1;
            rx_sr    <= '0;
            edge_cnt <= '0;
`ifdef SPI_LSB_FIRST_EN
            lsb_q    <= LSB_FIRST;
`endif
            // CPH=0 needs the first bit on the wire before the first SCK edge
            if (!CPH) begin
               MOSI  <= tx_ord[DATA_W-1];
               tx_sr <= {tx_ord[DATA_W-2:0], 1'b0};
            end else begin
               tx_sr <= tx_ord;
            end
         end
         if ((state == XFER) && tick) begin
            sck_q    <= ~sck_q;
            edge_cnt <= edge_cnt + 1'b1;
         end
         if (shift_ev) begin
            MOSI  <= tx_sr[DATA_W-1];
            tx_sr <= {tx_sr[DATA_W-2:0], 1'b0};
         end
         if (sample_ev)
            rx_sr <= {rx_sr[DATA_W-2:0], MISO};
         if (hold_done) begin
            RX_DATA <= rx_ord;
            BUSY    <= 1'b0;
            CS      <= '1;
         end
      end
   end

endmodule

// File: tb/tb_spi_master_param.sv
// Directed bench for spi_master_param at default parameters with an SPI slave model.
// Latency: DONE is expected 137 cycles after the cycle in which START is sampled.
// Backpressure: covers START while busy, START held across DONE, and reset mid-transfer.
module tb_spi_master_param;

   localparam int DW  = 16;
   localparam int DV  = 4;
   localparam int NC  = 2;
   localparam int LAT = DV * (2 * DW + 2) + 1;

   logic          CLK = 1'b0;
   logic          RESET = 1'b1;
   logic          CKP = 1'b0, CPH = 1'b0, START = 1'b0;
   logic [0:0]    CS_SEL = 1'b0;
   logic [DW-1:0] TX_DATA = '0;
   logic          MISO, MOSI, SCK, BUSY, DONE;
   logic [NC-1:0] CS;
   logic [DW-1:0] RX_DATA;
`ifdef SPI_LSB_FIRST_EN
   logic          LSB_FIRST = 1'b0;
`endif

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int done_cnt = 0;
   int cs_err = 0;
   logic [NC-1:0] cs_exp = 2'b10;

   typedef struct {
      logic [DW-1:0] rx;
      int            t0;
      bit            at_least;
   } exp_t;
   exp_t sb[$];
   exp_t e_mon;

   spi_master_param #(.DATA_W(DW), .DIV(DV), .NUM_CS(NC)) dut (
      .CLK(CLK), .RESET(RESET), .CKP(CKP), .CPH(CPH), .START(START),
      .CS_SEL(CS_SEL), .TX_DATA(TX_DATA),
`ifdef SPI_LSB_FIRST_EN
      .LSB_FIRST(LSB_FIRST),
`endif
      .MISO(MISO), .MOSI(MOSI), .SCK(SCK), .CS(CS),
      .RX_DATA(RX_DATA), .BUSY(BUSY), .DONE(DONE)
   );

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   // Slave model: MISO either looped from MOSI or shifted from slv_tx
   logic          loop = 1'b1;
   logic          slv_ckp = 1'b0, slv_cph = 1'b0, slv_miso = 1'b0, cs_prev = 1'b0;
   logic [DW-1:0] slv_tx = '0, slv_sh = '0, slv_rx = '0;
   wire           cs_act = ~&CS;
   assign MISO = loop ? MOSI : slv_miso;

   always @(SCK or cs_act) begin
      if (cs_act === 1'b1 && cs_prev !== 1'b1) begin
         slv_rx <= '0;
         if (!slv_cph) begin
            slv_miso <= slv_tx[DW-1];
            slv_sh   <= {slv_tx[DW-2:0], 1'b0};
         end else begin
            slv_sh <= slv_tx;
         end
      end else if (cs_act === 1'b1) begin
         if ((SCK !== slv_ckp) ^ slv_cph) begin
            slv_rx <= {slv_rx[DW-2:0], MOSI};
         end else begin
            slv_miso <= slv_sh[DW-1];
            slv_sh   <= {slv_sh[DW-2:0], 1'b0};
         end
      end
      cs_prev <= cs_act;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Output monitor: chip-select stability while busy, scoreboard pop on DONE
   always @(negedge CLK) begin
      if (BUSY === 1'b1 && CS !== cs_exp) cs_err <= cs_err + 1;
      if (DONE === 1'b1) begin
         done_cnt <= done_cnt + 1;
         if (sb.size() == 0) begin
            check("unexpected_done", 32'(DONE), 32'd0);
         end else begin
            e_mon = sb.pop_front();
            check("rx_data", 32'(RX_DATA), 32'(e_mon.rx));
            if (e_mon.at_least) check("done_gap_min", 32'(cyc - e_mon.t0 >= LAT), 32'd1);
            else                check("done_latency", 32'(cyc - e_mon.t0), 32'(LAT));
            check("busy_low_at_done", 32'(BUSY), 32'd0);
            check("cs_released_at_done", 32'(CS), 32'h3);
         end
      end
   end

   task automatic go(input logic ckp, input logic cph, input logic [0:0] sel, input logic [DW-1:0] tx);
      CKP = ckp; CPH = cph; CS_SEL = sel; TX_DATA = tx;
      START = 1'b1;
      @(negedge CLK);
      START = 1'b0;
   endtask

   task automatic wait_done(input int limit, input string tag);
      int n = 0;
      while (DONE !== 1'b1 && n < limit) begin
         @(negedge CLK);
         n++;
      end
      check(tag, 32'(DONE), 32'd1);
   endtask

   int base_cs, base_done;

   initial begin
      // Reset state
      repeat (3) @(negedge CLK);
      check("rst_cs", 32'(CS), 32'h3);
      check("rst_sck", 32'(SCK), 32'd0);
      check("rst_mosi", 32'(MOSI), 32'd0);
      check("rst_rx", 32'(RX_DATA), 32'd0);
      check("rst_busy", 32'(BUSY), 32'd0);
      check("rst_done", 32'(DONE), 32'd0);
      RESET = 1'b0;
      @(negedge CLK);
      CKP = 1'b1; #1;
      check("idle_sck_follows_hi", 32'(SCK), 32'd1);
      CKP = 1'b0; #1;
      check("idle_sck_follows_lo", 32'(SCK), 32'd0);
      @(negedge CLK);

      // Mode 0 loopback on CS0
      loop = 1'b1; slv_ckp = 1'b0; slv_cph = 1'b0; cs_exp = 2'b10; base_cs = cs_err;
      sb.push_back('{16'h0015, cyc, 1'b0});
      go(1'b0, 1'b0, 1'b0, 16'h0015);
      check("m0_busy_after_start", 32'(BUSY), 32'd1);
      check("m0_cs_active", 32'(CS), 32'h2);
      wait_done(300, "m0_done_seen");
      check("m0_cs_stable", 32'(cs_err - base_cs), 32'd0);
      check("m0_slave_rx", 32'(slv_rx), 32'h0015);
      @(negedge CLK);

      // Mode 3 with a slave returning 0x0062; live inputs disturbed mid-transfer
      loop = 1'b0; slv_ckp = 1'b1; slv_cph = 1'b1; slv_tx = 16'h0062; CKP = 1'b1;
      @(negedge CLK);
      check("m3_sck_idle_pre", 32'(SCK), 32'd1);
      base_cs = cs_err;
      sb.push_back('{16'h0062, cyc, 1'b0});
      go(1'b1, 1'b1, 1'b0, 16'h0015);
      CPH = 1'b0; TX_DATA = 16'hFFFF; CS_SEL = 1'b1;
      check("m3_sck_setup", 32'(SCK), 32'd1);
      wait_done(300, "m3_done_seen");
      check("m3_slave_rx", 32'(slv_rx), 32'h0015);
      check("m3_sck_idle_post", 32'(SCK), 32'd1);
      check("m3_cs_stable", 32'(cs_err - base_cs), 32'd0);
      @(negedge CLK);

      // CS_SEL=1, mode 1 loopback, second START at cycle 40 must be ignored
      loop = 1'b1; slv_ckp = 1'b0; slv_cph = 1'b1; cs_exp = 2'b01;
      base_cs = cs_err; base_done = done_cnt;
      sb.push_back('{16'hA5C3, cyc, 1'b0});
      go(1'b0, 1'b1, 1'b1, 16'hA5C3);
      repeat (38) @(negedge CLK);
      TX_DATA = 16'hFFFF; START = 1'b1;
      @(negedge CLK);
      START = 1'b0;
      wait_done(300, "sel1_done_seen");
      repeat (160) @(negedge CLK);
      check("sel1_single_done", 32'(done_cnt - base_done), 32'd1);
      check("sel1_cs_stable", 32'(cs_err - base_cs), 32'd0);
      check("sel1_cs_idle", 32'(CS), 32'h3);

      // Reset at cycle 60 of a transfer
      loop = 1'b1; slv_ckp = 1'b0; slv_cph = 1'b0; cs_exp = 2'b10; base_done = done_cnt;
      sb.push_back('{16'hBEEF, cyc, 1'b0});
      go(1'b0, 1'b0, 1'b0, 16'hBEEF);
      repeat (59) @(negedge CLK);
      RESET = 1'b1; #1;
      sb.delete();
      check("abort_cs", 32'(CS), 32'h3);
      check("abort_busy", 32'(BUSY), 32'd0);
      check("abort_rx", 32'(RX_DATA), 32'd0);
      check("abort_sck", 32'(SCK), 32'd0);
      @(negedge CLK);
      RESET = 1'b0;
      repeat (200) @(negedge CLK);
      check("abort_no_done", 32'(done_cnt - base_done), 32'd0);
      check("abort_rx_kept", 32'(RX_DATA), 32'd0);
      sb.push_back('{16'h3C5A, cyc, 1'b0});
      go(1'b0, 1'b0, 1'b0, 16'h3C5A);
      wait_done(300, "post_abort_done_seen");
      @(negedge CLK);

      // START held across DONE: back-to-back transfers
      base_done = done_cnt; base_cs = cs_err;
      sb.push_back('{16'h00FF, cyc, 1'b0});
      sb.push_back('{16'h0F0F, cyc + LAT, 1'b1});
      CKP = 1'b0; CPH = 1'b0; CS_SEL = 1'b0; TX_DATA = 16'h00FF; START = 1'b1;
      @(negedge CLK);
      wait_done(300, "b2b_first_seen");
      check("b2b_cs_gap", 32'(CS), 32'h3);
      TX_DATA = 16'h0F0F;
      @(negedge CLK);
      START = 1'b0;
      check("b2b_restart_busy", 32'(BUSY), 32'd1);
      check("b2b_restart_cs", 32'(CS), 32'h2);
      wait_done(300, "b2b_second_seen");
      @(negedge CLK);
      check("b2b_two_done", 32'(done_cnt - base_done), 32'd2);
      check("b2b_cs_stable", 32'(cs_err - base_cs), 32'd0);

`ifdef SPI_LSB_FIRST_EN
      // LSB-first loopback
      @(negedge CLK);
      loop = 1'b1; slv_ckp = 1'b0; slv_cph = 1'b0; LSB_FIRST = 1'b1;
      sb.push_back('{16'h8001, cyc, 1'b0});
      go(1'b0, 1'b0, 1'b0, 16'h8001);
      LSB_FIRST = 1'b0;
      wait_done(300, "lsb_done_seen");
      check("lsb_mosi_order", 32'(slv_rx), 32'h8001);
`endif

      repeat (2) @(negedge CLK);
      check("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/spi_master_param.md
SPI_MASTER_PARAM -- requirements
Module: spi_master_param

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning bits per transfer (legal range 2..32).
REQ-002 SHALL have parameter DIV, default 4, meaning CLK cycles per SCK half-period (legal minimum 2).
REQ-003 SHALL have parameter NUM_CS, default 2, meaning chip-select lines (legal minimum 1).
REQ-004 SHALL have port CLK  input  1  system clock; all state changes on its rising edge.
REQ-005 SHALL have port RESET  input  1  reset, asynchronous and active-high.
REQ-006 SHALL have port CKP  input  1  SCK idle polarity.
REQ-007 SHALL have port CPH  input  1  clock phase; 0 = sample on leading edge, 1 = sample on trailing edge.
REQ-008 SHALL have port START  input  1  transfer request.
REQ-009 SHALL have port CS_SEL  input  $clog2(NUM_CS) (min 1)  target slave index.
REQ-010 SHALL have port TX_DATA  input  DATA_W  word to send.
REQ-011 SHALL have port MISO  input  1  serial data from slave.
REQ-012 SHALL have port MOSI  output  1  serial data to slave.
REQ-013 SHALL have port SCK  output  1  serial clock.
REQ-014 SHALL have port CS  output  NUM_CS  active-low chip selects.
REQ-015 SHALL have port RX_DATA  output  DATA_W  last received word.
REQ-016 SHALL have port BUSY  output  1  high from the cycle after START is accepted until DONE.
REQ-017 SHALL have port DONE  output  1  one-cycle completion pulse.

Function
REQ-018 SHALL implement FSM IDLE -> SETUP -> XFER -> HOLD -> IDLE; START is accepted only in IDLE.
REQ-019 SHALL, on accepting START, latch TX_DATA, CKP, CPH and CS_SEL; input changes during a transfer have no effect.
REQ-020 SHALL drive CS[CS_SEL] low for the whole of SETUP, XFER and HOLD; all other CS bits stay high.
REQ-021 SHALL keep SETUP and HOLD at DIV cycles each, with SCK at the latched idle level.
REQ-022 SHALL, in XFER, produce DATA_W SCK periods, toggling SCK every DIV cycles, for 2*DATA_W edges.
REQ-023 SHALL, when CPH=0, present the first MOSI bit on SETUP entry, sample MISO on leading edges and shift MOSI on trailing edges.
REQ-024 SHALL, when CPH=1, shift MOSI on leading edges and sample MISO on trailing edges.
REQ-025 SHALL transmit and receive MSB first unless REQ-036 applies.
REQ-026 SHALL update RX_DATA and pulse DONE for exactly one cycle on HOLD exit; BUSY drops in that same cycle.
REQ-027 SHALL assert DONE exactly DIV*(2*DATA_W+2)+1 cycles after the cycle START is sampled (137 at defaults).
REQ-028 SHALL accept a START asserted during the DONE cycle, giving back-to-back transfers with CS released for at least one cycle.
REQ-029 SHALL ignore START while BUSY, with no queuing.
REQ-030 SHALL, when CS_SEL >= NUM_CS, run the full timing with every CS bit high.
REQ-031 SHALL hold SCK equal to the live CKP input in IDLE.

Reset
REQ-032 SHALL, while RESET is high, force: FSM=IDLE, SCK=0, MOSI=0, CS all ones, RX_DATA=0, BUSY=0, DONE=0, counters=0.
REQ-033 SHALL, when RESET is asserted mid-transfer, abort immediately with no DONE pulse and leave RX_DATA at 0.

Configuration
REQ-034 SHALL recognise the macro SPI_LSB_FIRST_EN.
REQ-035 SHALL, without SPI_LSB_FIRST_EN, have no LSB_FIRST port and always use MSB first.
REQ-036 SHALL, with SPI_LSB_FIRST_EN, add input LSB_FIRST (1 bit), latched at START, where 1 sends and assembles LSB first.

Structure
REQ-037 SHALL take the FSM state encoding, mode constants (MODE0..MODE3 as {CKP,CPH}) and the DIV/DATA_W legality limits from the shared package spi_pkg.
REQ-038 SHALL use sub-module spi_clkgen, which counts DIV and emits half-period tick, leading-edge and trailing-edge strobes.

Verification
REQ-039 SHALL verify: mode 0, MISO tied to MOSI, TX_DATA=16'h0015 -> RX_DATA=16'h0015, DONE at cycle 137, CS=2'b10 throughout.
REQ-040 SHALL verify: mode 3, slave model returning 16'h0062, TX_DATA=16'h0015 -> RX_DATA=16'h0062, slave captured 16'h0015, SCK idles high.
REQ-041 SHALL verify: CS_SEL=1, START pulsed again at cycle 40 -> single transfer only, CS=2'b01, one DONE pulse.
REQ-042 SHALL verify: RESET asserted at cycle 60 of a transfer -> CS=2'b11, BUSY=0, no DONE, RX_DATA=0; the next START completes normally.
REQ-043 SHALL verify: START held high across DONE -> second transfer starts, CS high for at least one cycle between transfers, two DONE pulses 137 cycles apart or more.
REQ-044 SHALL verify: SPI_LSB_FIRST_EN defined, LSB_FIRST=1, loopback, TX_DATA=16'h8001 -> MOSI bit order 1,0,...,0,1 and RX_DATA=16'h8001.
